jtkcpu_intctrl: RTL and testbench
=================================

Name: jtkcpu_intctrl

Overview:
- Interrupt and reset sequencer sitting directly upstream of the memory controller.
- Samples NMI, FIRQ and IRQ, resolves priority against the CC masks, and requests register stacking from the control unit.
- Once stacking is done, it drives the one-hot intvec that makes the memory controller fetch the vector.
- After reset it issues the RST vector fetch without any stacking.

Parameters:
- NMI_ARM_RST, 0, NMI armed state after reset (0 = armed only once S is first loaded).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cen  in  1  clock enable, same rate as the memory controller's cen2; all state advances only when cen=1
- nmi_n  in  1  NMI, falling-edge triggered
- firq_n  in  1  FIRQ, level, active low
- irq_n  in  1  IRQ, level, active low
- cc_i  in  1  CC I mask bit
- cc_f  in  1  CC F mask bit
- s_ld  in  1  pulse: S register written (arms NMI)
- op_start  in  1  instruction boundary; next byte is an opcode
- stack_done  in  1  pulse: control unit finished pushing registers
- up_pc  in  1  pulse from memory controller: PC loaded with the vector
- int_req  out  1  request for the control unit to begin interrupt stacking
- int_fast  out  1  1 = FIRQ (push PC and CC only), 0 = push all registers
- intvec  out  4  one-hot vector select: 0001 IRQ, 0010 FIRQ, 0100 NMI, 1000 RST, 0000 none
- set_e  out  1  pulse: set CC E bit before CC is pushed
- set_if  out  2  pulse {F,I}: mask bits to set after stacking
- busy  out  1  sequence in progress (IDLE excluded)

Behaviour:
- Reset values:
  - state=RSTV, intvec=0, int_req=0, int_fast=0, set_e=0, set_if=0, busy=1.
  - nmi_armed=NMI_ARM_RST, nmi_pend=0.
  - Sampled input registers reset to 1 (inactive).
- Input sampling: nmi_n, firq_n and irq_n are registered on each cen; logic uses only the registered copies.
- NMI:
  - nmi_pend is set when the registered nmi_n goes 1 to 0 and nmi_armed=1.
  - A one-cycle low pulse is enough to latch it.
  - nmi_pend is cleared on entry to VEC for NMI.
  - s_ld sets nmi_armed; nmi_armed clears only on reset.
  - Edges seen while unarmed are discarded.
- Pending evaluation happens only when op_start=1 in IDLE. Priority is NMI > FIRQ > IRQ:
  - NMI: nmi_pend.
  - FIRQ: !firq_s && !cc_f.
  - IRQ: !irq_s && !cc_i.
- States:
  - RSTV: on the first cen after reset, intvec=1000 for exactly one cen cycle, then go to WPC. No stacking and no int_req.
  - IDLE: if a source wins at op_start, latch its code, assert int_req, and set int_fast (1 only for FIRQ). Pulse set_e for one cen with value 1 for NMI/IRQ and 0 for FIRQ (set_e stays low on FIRQ). Go to STK.
  - STK: hold int_req until stack_done, then drop int_req and go to VEC.
  - VEC: drive intvec=latched code for exactly one cen cycle. In the same cycle pulse set_if: IRQ = 01, FIRQ = 11, NMI = 11. Go to WPC.
  - WPC: intvec=0. On up_pc go to IDLE and clear busy, int_fast and the latched code.
- Boundary cases:
  - An interrupt source that rises or is masked after being latched in IDLE does not cancel the sequence.
  - A new NMI edge during STK/VEC/WPC is latched in nmi_pend and served at the next op_start after returning to IDLE.
  - stack_done outside STK is ignored. up_pc outside WPC is ignored.
  - intvec is never held longer than one cen cycle, so the memory controller reloads the vector address exactly once.
  - With cen=0 all outputs hold their value; single-cycle pulses stretch across cen=0 cycles until the next cen.
  - Reset mid-sequence aborts immediately to the reset values and re-runs RSTV.

Test Plan:
- Reset release with cen every cycle -> intvec=1000 for one cycle, int_req=0. After up_pc, busy=0 and state is IDLE.
- irq_n=0, cc_i=0, op_start pulse -> int_req=1, int_fast=0, set_e pulse. stack_done -> intvec=0001 for one cycle and set_if=01. up_pc -> busy=0.
- irq_n=0, cc_i=1 for 50 cycles with op_start pulses -> int_req stays 0. Then firq_n=0, cc_f=0 -> int_fast=1, no set_e pulse, intvec=0010, set_if=11.
- nmi_n 1-cycle low pulse before any s_ld -> ignored. After s_ld, another 1-cycle pulse together with firq_n=0, then op_start -> NMI served first (intvec=0100, set_if=11). FIRQ is served at the following op_start.
- NMI edge during STK of an IRQ sequence -> IRQ completes (intvec=0001), then the next op_start starts the NMI sequence.
- rst asserted in STK with int_req=1 -> int_req=0 asynchronously. After release, RSTV issues intvec=1000 and nmi_pend=0.

Source files
------------

// File: rtl/jtkcpu_intctrl_if.sv
// rtl/jtkcpu_intctrl_if.sv - interrupt sources, control-unit handshake and vector outputs of jtkcpu_intctrl
// master: the driving side (CPU core / bench); slave: the sequencer itself
`timescale 1ns/1ps
interface jtkcpu_intctrl_if;
    logic       nmi_n;
    logic       firq_n;
    logic       irq_n;
    logic       cc_i;
    logic       cc_f;
    logic       s_ld;
    logic       op_start;
    logic       stack_done;
    logic       up_pc;
    logic       int_req;
    logic       int_fast;
    logic [3:0] intvec;
    logic       set_e;
    logic [1:0] set_if;
    logic       busy;

    modport master (
        output nmi_n, firq_n, irq_n, cc_i, cc_f, s_ld, op_start, stack_done, up_pc,
        input  int_req, int_fast, intvec, set_e, set_if, busy
    );

    modport slave (
        input  nmi_n, firq_n, irq_n, cc_i, cc_f, s_ld, op_start, stack_done, up_pc,
        output int_req, int_fast, intvec, set_e, set_if, busy
    );
endinterface

// File: rtl/jtkcpu_intctrl.sv
// rtl/jtkcpu_intctrl.sv - interrupt/reset sequencer feeding vector fetches to the memory controller
// Ports: clk, rst (async, active high), cen (clock enable);
//        bus.slave: nmi_n/firq_n/irq_n sources, cc_i/cc_f masks, s_ld, op_start,
//        stack_done, up_pc in; int_req, int_fast, intvec (one-hot), set_e, set_if, busy out.
`timescale 1ns/1ps
module jtkcpu_intctrl #(
    parameter bit NMI_ARM_RST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    jtkcpu_intctrl_if.slave    bus
);
    typedef enum logic [2:0] {RSTV, IDLE, STK, VEC, WPC} state_t;

    localparam logic [3:0] V_IRQ  = 4'b0001;
    localparam logic [3:0] V_FIRQ = 4'b0010;
    localparam logic [3:0] V_NMI  = 4'b0100;
    localparam logic [3:0] V_RST  = 4'b1000;

    state_t     state, state_nx;
    logic       nmi_s, nmi_l, firq_s, irq_s;
    logic       nmi_armed, nmi_pend, nmi_clr;
    logic [3:0] code, code_nx, win;
    logic       int_req, int_req_nx;
    logic       int_fast, int_fast_nx;
    logic [3:0] intvec, intvec_nx;
    logic       set_e, set_e_nx;
    logic [1:0] set_if, set_if_nx;
    logic       busy, busy_nx;

    assign bus.int_req  = int_req;
    assign bus.int_fast = int_fast;
    assign bus.intvec   = intvec;
    assign bus.set_e    = set_e;
    assign bus.set_if   = set_if;
    assign bus.busy     = busy;

    // nmi_l is the previous sample of nmi_s, so a single low sample still
    // produces a 1->0 transition between the two registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_s     <= 1'b1;
            nmi_l     <= 1'b1;
            firq_s    <= 1'b1;
            irq_s     <= 1'b1;
            nmi_armed <= NMI_ARM_RST;
            nmi_pend  <= 1'b0;
        end else if (cen) begin
            nmi_s  <= bus.nmi_n;
            nmi_l  <= nmi_s;
            firq_s <= bus.firq_n;
            irq_s  <= bus.irq_n;
            if (bus.s_ld) nmi_armed <= 1'b1;
            if (nmi_clr) nmi_pend <= 1'b0;
            // a fresh edge wins over the clear of the NMI being vectored
            if (nmi_l && !nmi_s && nmi_armed) nmi_pend <= 1'b1;
        end
    end

    always_comb begin
        win = 4'b0000;
        if (nmi_pend)                 win = V_NMI;
        else if (!firq_s && !bus.cc_f) win = V_FIRQ;
        else if (!irq_s && !bus.cc_i)  win = V_IRQ;
    end

    always_comb begin
        state_nx    = state;
        code_nx     = code;
        int_req_nx  = int_req;
        int_fast_nx = int_fast;
        busy_nx     = busy;
        intvec_nx   = 4'b0000;  // vector and pulses last one cen cycle
        set_e_nx    = 1'b0;
        set_if_nx   = 2'b00;
        nmi_clr     = 1'b0;
        case (state)
            RSTV: begin
                intvec_nx = V_RST;
                state_nx  = WPC;
            end
            IDLE: begin
                if (bus.op_start && win != 4'b0000) begin
                    code_nx     = win;
                    int_req_nx  = 1'b1;
                    int_fast_nx = (win == V_FIRQ);
                    set_e_nx    = (win != V_FIRQ);
                    busy_nx     = 1'b1;
                    state_nx    = STK;
                end
            end
            STK: begin
                if (bus.stack_done) begin
                    int_req_nx = 1'b0;
                    intvec_nx  = code;
                    set_if_nx  = {code != V_IRQ, 1'b1};
                    nmi_clr    = (code == V_NMI);
                    state_nx   = VEC;
                end
            end
            VEC: state_nx = WPC;
            WPC: begin
                if (bus.up_pc) begin
                    busy_nx     = 1'b0;
                    int_fast_nx = 1'b0;
                    code_nx     = 4'b0000;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = RSTV;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RSTV;
            code     <= 4'b0000;
            int_req  <= 1'b0;
            int_fast <= 1'b0;
            intvec   <= 4'b0000;
            set_e    <= 1'b0;
            set_if   <= 2'b00;
            busy     <= 1'b1;
        end else if (cen) begin
            state    <= state_nx;
            code     <= code_nx;
            int_req  <= int_req_nx;
            int_fast <= int_fast_nx;
            intvec   <= intvec_nx;
            set_e    <= set_e_nx;
            set_if   <= set_if_nx;
            busy     <= busy_nx;
        end
    end
endmodule

// File: tb/tb_jtkcpu_intctrl.sv
// tb/tb_jtkcpu_intctrl.sv - self-checking bench for jtkcpu_intctrl
`timescale 1ns/1ps
module tb_jtkcpu_intctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    int   checks = 0;
    int   failures = 0;

    jtkcpu_intctrl_if bus();

    jtkcpu_intctrl #(.NMI_ARM_RST(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] C_IRQ  = 4'b0001;
    localparam logic [3:0] C_FIRQ = 4'b0010;
    localparam logic [3:0] C_NMI  = 4'b0100;
    localparam logic [3:0] C_RST  = 4'b1000;

    typedef struct {
        logic       np;
        logic       fq;
        logic       iq;
        logic       cf;
        logic       ci;
        logic [3:0] code;
        logic       fast;
        logic       se;
        logic [1:0] sif;
    } vec_t;

    vec_t tbl[8];

    // reference model state: what the programmer-visible NMI rules imply
    bit model_armed;
    bit model_pend;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.nmi_n = 1'b1; bus.firq_n = 1'b1; bus.irq_n = 1'b1;
        bus.cc_i = 1'b1; bus.cc_f = 1'b1; bus.s_ld = 1'b0;
        bus.op_start = 1'b0; bus.stack_done = 1'b0; bus.up_pc = 1'b0;
    endtask

    task automatic nmi_pulse();
        bus.nmi_n = 1'b0;
        tick();
        bus.nmi_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic s_ld_pulse();
        bus.s_ld = 1'b1;
        tick();
        bus.s_ld = 1'b0;
    endtask

    task automatic op_pulse();
        bus.op_start = 1'b1;
        tick();
        bus.op_start = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        cen = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk1("rst_int_req", bus.int_req, 1'b0);
        chk1("rst_int_fast", bus.int_fast, 1'b0);
        chk4("rst_intvec", bus.intvec, 4'b0000);
        chk1("rst_set_e", bus.set_e, 1'b0);
        chk4("rst_set_if", {2'b00, bus.set_if}, 4'b0000);
        chk1("rst_busy", bus.busy, 1'b1);
        rst = 1'b0;
        tick();
        chk4("rstv_intvec", bus.intvec, C_RST);
        chk1("rstv_int_req", bus.int_req, 1'b0);
        tick();
        chk4("rstv_intvec_one", bus.intvec, 4'b0000);
        chk1("rstv_busy", bus.busy, 1'b1);
        bus.up_pc = 1'b1;
        tick();
        bus.up_pc = 1'b0;
        chk1("rstv_busy_clr", bus.busy, 1'b0);
        model_armed = 1'b0;
        model_pend  = 1'b0;
    endtask

    // One op_start boundary and, if a source wins, the full stacking sequence.
    task automatic episode(input logic np, input logic fq, input logic iq,
                           input logic cf, input logic ci,
                           input logic [3:0] ec, input logic ef, input logic es,
                           input logic [1:0] esif, input bit stk_nmi, input bit perturb);
        logic [31:0] r;
        bus.firq_n = fq; bus.irq_n = iq; bus.cc_f = cf; bus.cc_i = ci;
        tick();
        tick();
        if (np) nmi_pulse();
        op_pulse();
        chk1("ep_int_req", bus.int_req, ec != 4'b0000);
        chk1("ep_int_fast", bus.int_fast, ef);
        chk1("ep_set_e", bus.set_e, es);
        chk1("ep_busy", bus.busy, ec != 4'b0000);
        if (ec != 4'b0000) begin
            if (perturb) begin
                r = $urandom();
                bus.firq_n = r[0]; bus.irq_n = r[1]; bus.cc_f = r[2]; bus.cc_i = r[3];
            end
            if (stk_nmi) nmi_pulse();
            else tick();
            chk1("stk_set_e_off", bus.set_e, 1'b0);
            chk1("stk_int_req", bus.int_req, 1'b1);
            bus.stack_done = 1'b1;
            tick();
            bus.stack_done = 1'b0;
            chk1("vec_int_req", bus.int_req, 1'b0);
            chk4("vec_intvec", bus.intvec, ec);
            chk4("vec_set_if", {2'b00, bus.set_if}, {2'b00, esif});
            tick();
            chk4("wpc_intvec", bus.intvec, 4'b0000);
            chk4("wpc_set_if", {2'b00, bus.set_if}, 4'b0000);
            chk1("wpc_busy", bus.busy, 1'b1);
            bus.up_pc = 1'b1;
            tick();
            bus.up_pc = 1'b0;
            chk1("idle_busy", bus.busy, 1'b0);
            chk1("idle_int_fast", bus.int_fast, 1'b0);
        end
    endtask

    function automatic logic [3:0] model_winner(input logic fq, input logic iq,
                                                input logic cf, input logic ci);
        if (model_pend)      return C_NMI;
        if (!fq && !cf)      return C_FIRQ;
        if (!iq && !ci)      return C_IRQ;
        return 4'b0000;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [3:0]  w;
        bit          stk;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_IRQ,   1'b0, 1'b1, 2'b01};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b00};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_FIRQ,  1'b1, 1'b0, 2'b11};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_IRQ,   1'b0, 1'b1, 2'b01};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NMI,   1'b0, 1'b1, 2'b11};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, C_NMI,   1'b0, 1'b1, 2'b11};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00};

        do_reset();

        // NMI edge before S is loaded is discarded
        nmi_pulse();
        op_pulse();
        chk1("nmi_unarmed", bus.int_req, 1'b0);
        s_ld_pulse();
        // armed NMI plus active FIRQ: NMI first, then FIRQ
        episode(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C_NMI, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        episode(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_FIRQ, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1);

        // masked IRQ never requested
        bus.irq_n = 1'b0; bus.cc_i = 1'b1; bus.firq_n = 1'b1; bus.cc_f = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i % 5 == 0) bus.op_start = 1'b1;
            tick();
            bus.op_start = 1'b0;
            if (i % 5 == 0) chk1("irq_masked", bus.int_req, 1'b0);
        end
        episode(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_FIRQ, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++)
            episode(tbl[i].np, tbl[i].fq, tbl[i].iq, tbl[i].cf, tbl[i].ci,
                    tbl[i].code, tbl[i].fast, tbl[i].se, tbl[i].sif, 1'b0, 1'b1);

        // NMI edge during IRQ stacking is served afterwards
        episode(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_IRQ, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
        episode(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, C_NMI, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);

        // stack_done / up_pc outside their states are ignored
        idle_inputs();
        tick();
        bus.stack_done = 1'b1; bus.up_pc = 1'b1;
        tick();
        bus.stack_done = 1'b0; bus.up_pc = 1'b0;
        tick();
        chk4("stray_intvec", bus.intvec, 4'b0000);
        chk1("stray_busy", bus.busy, 1'b0);
        chk1("stray_int_req", bus.int_req, 1'b0);

        // cen=0 stretches pulses and holds state
        bus.irq_n = 1'b0; bus.cc_i = 1'b0;
        tick(); tick();
        op_pulse();
        chk1("cen_set_e", bus.set_e, 1'b1);
        cen = 1'b0;
        tick(); tick();
        bus.stack_done = 1'b1;
        tick();
        bus.stack_done = 1'b0;
        chk1("cen_set_e_hold", bus.set_e, 1'b1);
        chk1("cen_int_req_hold", bus.int_req, 1'b1);
        cen = 1'b1;
        tick();
        chk1("cen_set_e_off", bus.set_e, 1'b0);
        chk1("cen_stk_ignored", bus.int_req, 1'b1);
        bus.stack_done = 1'b1;
        tick();
        bus.stack_done = 1'b0;
        chk4("cen_intvec", bus.intvec, C_IRQ);
        cen = 1'b0;
        tick(); tick();
        chk4("cen_intvec_hold", bus.intvec, C_IRQ);
        chk4("cen_set_if_hold", {2'b00, bus.set_if}, 4'b0001);
        cen = 1'b1;
        tick();
        chk4("cen_intvec_off", bus.intvec, 4'b0000);
        bus.up_pc = 1'b1;
        tick();
        bus.up_pc = 1'b0;
        chk1("cen_busy", bus.busy, 1'b0);

        // asynchronous reset mid-stacking with an NMI pending
        tick(); tick();
        op_pulse();
        nmi_pulse();
        chk1("arst_pre_int_req", bus.int_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_int_req", bus.int_req, 1'b0);
        chk1("arst_busy", bus.busy, 1'b1);
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk4("arst_rstv", bus.intvec, C_RST);
        tick();
        bus.up_pc = 1'b1;
        tick();
        bus.up_pc = 1'b0;
        op_pulse();
        chk1("arst_nmi_pend_clr", bus.int_req, 1'b0);

        // randomized episodes against the reference model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            if (r[7:5] == 3'd0) begin
                s_ld_pulse();
                model_armed = 1'b1;
            end
            if (r[4] && r[8] && model_armed) model_pend = 1'b1;
            w = model_winner(r[0], r[1], r[2], r[3]);
            stk = (w != 4'b0000) && (w != C_NMI) && r[9];
            episode(r[4] && r[8], r[0], r[1], r[2], r[3], w,
                    w == C_FIRQ, (w == C_NMI) || (w == C_IRQ),
                    (w == C_IRQ) ? 2'b01 : ((w != 4'b0000) ? 2'b11 : 2'b00),
                    stk, 1'b1);
            if (w == C_NMI) model_pend = 1'b0;
            if (stk && model_armed) model_pend = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
